// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, runs a one-outstanding-request
// handshake to instruction memory and presents fetched instructions to decode.
module fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               taken,
    input  logic [ADDR_W-1:0]  branch_address,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic [INSTR_W-1:0] Instruction,
    output logic               instr_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2,
        VALID  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0]  old_addr, old_addr_nxt;
    logic [ADDR_W-1:0]  target;
    logic               capture;

    assign target = branch_address & ALIGN_MASK;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        old_addr_nxt = old_addr;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (taken) fetch_pc_nxt = target;
            end

            REQ: begin
                if (taken) begin
                    fetch_pc_nxt = target;
                    // An unacked request cannot be withdrawn: remember its address
                    // and drain it in SQUASH before fetching the target.
                    if (!imem_ack) begin
                        old_addr_nxt = fetch_pc;
                        state_nxt    = SQUASH;
                    end
                end else if (imem_ack) begin
                    capture      = 1'b1;
                    fetch_pc_nxt = fetch_pc + STEP;
                    state_nxt    = VALID;
                end
            end

            SQUASH: begin
                if (taken)    fetch_pc_nxt = target;
                if (imem_ack) state_nxt    = REQ;
            end

            VALID: begin
                if (taken) begin
                    fetch_pc_nxt = target;
                    state_nxt    = REQ;
                end else if (!stall) begin
                    state_nxt = REQ;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-low, so it is sampled only on the
    // clock edge and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            old_addr    <= RESET_PC;
            pc          <= RESET_PC;
            Instruction <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            old_addr <= old_addr_nxt;
            if (capture) begin
                Instruction <= imem_rdata;
                pc          <= fetch_pc;
            end
        end
    end

    assign imem_req    = (state == REQ) || (state == SQUASH);
    assign imem_addr   = (state == SQUASH) ? old_addr : fetch_pc;
    assign instr_valid = (state == VALID);
    assign pc_next     = pc + STEP;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam int          AW    = 32;
    localparam int          IW    = 32;
    localparam logic [31:0] RST   = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'h0000_0100;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          reset, taken, stall, imem_ack;
    logic [AW-1:0] branch_address;
    logic [IW-1:0] imem_rdata;

    logic          imem_req, instr_valid;
    logic [AW-1:0] imem_addr, pc, pc_next;
    logic [IW-1:0] instr;

    logic          b_imem_req, b_instr_valid;
    logic [AW-1:0] b_imem_addr, b_pc, b_pc_next;
    logic [IW-1:0] b_instr;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RST)) dut (
        .clk(clk), .reset(reset), .taken(taken), .branch_address(branch_address),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc_next(pc_next),
        .Instruction(instr), .instr_valid(instr_valid)
    );

    fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RST_B)) dut_b (
        .clk(clk), .reset(reset), .taken(taken), .branch_address(branch_address),
        .stall(stall), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(b_pc), .pc_next(b_pc_next),
        .Instruction(b_instr), .instr_valid(b_instr_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding request, an optional "discard" mark on it,
    // and the instruction currently presented to decode.
    logic        m_out, m_discard, m_pres;
    logic [31:0] m_req_addr, m_next, m_pc, m_instr;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_out = 1'b0; m_discard = 1'b0; m_pres = 1'b0;
        m_next = RST; m_req_addr = RST; m_pc = RST; m_instr = '0;
    endtask

    task automatic model_edge(input logic r, input logic t, input logic [31:0] ba,
                              input logic st, input logic ak, input logic [31:0] rd);
        if (!r) begin
            model_reset();
        end else if (!m_out) begin
            if (t) m_next = align(ba);
            if (t || !m_pres || !st) begin
                m_pres     = 1'b0;
                m_out      = 1'b1;
                m_req_addr = m_next;
            end
        end else if (m_discard) begin
            if (t) m_next = align(ba);
            if (ak) begin
                m_discard  = 1'b0;
                m_req_addr = m_next;
            end
        end else if (t) begin
            m_next = align(ba);
            if (ak) m_req_addr = m_next;
            else    m_discard  = 1'b1;
        end else if (ak) begin
            m_instr = rd;
            m_pc    = m_req_addr;
            m_pres  = 1'b1;
            m_out   = 1'b0;
            m_next  = m_req_addr + 32'd4;
        end
    endtask

    task automatic compare();
        check("imem_req", imem_req, m_out);
        check("instr_valid", instr_valid, m_pres);
        check("pc", pc, m_pc);
        check("pc_next", pc_next, m_pc + 32'd4);
        check("instruction", instr, m_instr);
        if (m_out) check("imem_addr", imem_addr, m_req_addr);
    endtask

    // Drive one cycle's inputs at the falling edge, advance the model on the
    // rising edge, and compare at the next falling edge.
    task automatic step(input logic r, input logic t, input logic [31:0] ba,
                        input logic st, input logic ak);
        reset          = r;
        taken          = t;
        branch_address = ba;
        stall          = st;
        imem_ack       = ak & m_out;
        imem_rdata     = m_out ? (m_req_addr ^ SALT) : $urandom;
        @(posedge clk);
        model_edge(r, t, ba, st, imem_ack, imem_rdata);
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset = 1'b0; taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        branch_address = '0; imem_rdata = '0;
        model_reset();
        @(negedge clk);

        // Reset held for three cycles, then released.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_addr", imem_addr, RST);
        check("rst_pc_next", pc_next, RST + 32'd4);
        check("rst_b_addr", b_imem_addr, RST_B);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        check("first_b_req", b_imem_req, 1'b1);
        check("first_b_addr", b_imem_addr, RST_B);

        // Zero-wait sequential fetch.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            check("seq_valid", instr_valid, 1'b1);
            check("seq_pc", pc, 32'(i * 4));
            check("seq_instr", instr, 32'(i * 4) ^ SALT);
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            check("seq_gap", instr_valid, 1'b0);
        end
        check("seq_next_addr", imem_addr, 32'h10);

        // Two wait states, then stall held three cycles.
        repeat (2) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            check("wait_addr", imem_addr, 32'h10);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            check("stall_no_req", imem_req, 1'b0);
            check("stall_hold", instr, 32'h10 ^ SALT);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("after_stall_addr", imem_addr, 32'h14);

        // Redirect from VALID, taking priority over stall.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h43, 1'b1, 1'b0);
        check("redir_valid_drop", instr_valid, 1'b0);
        check("redir_addr", imem_addr, 32'h40);

        // Redirect while a request is pending: old address drains first.
        step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        check("squash_addr", imem_addr, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("squash_hold", imem_addr, 32'h40);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("squash_discard", instr_valid, 1'b0);
        check("squash_target", imem_addr, 32'h200);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("squash_first_pc", pc, 32'h200);

        // Address wrap.
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("wrap_pc_next", pc_next, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_fetch", imem_addr, 32'h0);

        // Reset in the middle of an unacked request.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("midrst_req", imem_req, 1'b0);
        check("midrst_pc", pc, RST);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("midrst_restart", imem_addr, RST);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic        r, t, st, ak;
            logic [31:0] ba;
            r  = ($urandom_range(0, 299) != 0);
            t  = ($urandom_range(0, 7) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            st = ($urandom_range(0, 2) == 0);
            ak = ($urandom_range(0, 1) == 1);
            step(r, t, ba, st, ak);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the program counter and drives the instruction-memory request handshake for the single-issue core. It owns the fetch PC, issues one memory request at a time, and presents each returned instruction with its PC to decode. It also applies absolute branch redirects, including squashing a fetch already in flight. It sits between the branch-resolution logic and the external instruction memory, upstream of ID.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width

- clk  in  1  main clock, rising edge
- reset  in  1  synchronous, active-low reset
- taken  in  1  branch redirect, single-cycle qualified pulse
- branch_address  in  ADDR_W  absolute redirect target, bits [1:0] ignored (forced 0)
- stall  in  1  decode not accepting; instruction held while 1
- imem_req  out  1  memory request valid
- imem_addr  out  ADDR_W  request address, stable while imem_req=1 until ack
- imem_ack  in  1  memory returns data this cycle, only meaningful when imem_req=1
- imem_rdata  in  INSTR_W  returned instruction, valid with imem_ack
- pc  out  ADDR_W  address of the presented Instruction
- pc_next  out  ADDR_W  pc + 4, combinational from pc
- Instruction  out  INSTR_W  registered fetched instruction
- instr_valid  out  1  Instruction/pc valid for decode

## Operation
- Reset values: state IDLE, fetch_pc=RESET_PC, pc=RESET_PC, pc_next=RESET_PC+4, Instruction=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, squash=0.
- States: IDLE, REQ, SQUASH, VALID.
- IDLE: imem_req=0. Next REQ. If taken, fetch_pc<=branch_address first.
- REQ: imem_req=1, imem_addr=fetch_pc. On imem_ack: Instruction<=imem_rdata, pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4, go VALID. With no ack, stay.
- VALID: imem_req=0, outputs held. A cycle with instr_valid=1 and stall=0 consumes the instruction; instr_valid<=0, go REQ.
- Redirect (taken=1), which has priority over stall and ack:
  - IDLE or VALID: fetch_pc<=branch_address, instr_valid<=0, go REQ.
  - REQ with imem_ack the same cycle: discard imem_rdata, fetch_pc<=branch_address, go REQ. No instr_valid.
  - REQ without ack: a request cannot be withdrawn. Latch fetch_pc<=branch_address, go SQUASH. imem_addr keeps the old address.
  - SQUASH: imem_req=1 at the old address. On ack, discard data and go REQ (new address). A further taken in SQUASH overwrites fetch_pc only.
- Arithmetic: all +4 are modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 = 0. No overflow flag.
- Reset low in any state (including mid-request): next cycle all outputs at reset values and imem_req=0. The outstanding request is abandoned. Memory is reset on the same signal.

## Timing
- Edge E0 is the first rising edge with reset=1; it moves IDLE→REQ. imem_req=1 in cycle after E0.
- Zero-wait memory (ack in the request cycle): instr_valid=1 on the following cycle. Peak throughput is 1 instruction per 2 cycles (REQ, VALID).
- N wait states add N cycles in REQ. imem_addr/imem_req must not change while waiting.
- stall held k cycles in VALID extends VALID by k cycles, with no new request.
- Redirect latency: taken in VALID/IDLE → request to the target next cycle. taken in REQ without ack → target request the cycle after the old ack.
- Instruction from a squashed or discarded fetch never appears with instr_valid=1.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release. Check all reset values. First imem_req=1 with imem_addr=0x0 one cycle after release. RESET_PC=0x100 gives addr 0x100.
- Sequential zero-wait: ack every request with rdata=addr^0xA5A5_0000, stall=0. Check pc sequence 0,4,8,C, instr_valid pattern 0101…, and pc_next=pc+4.
- Wait states plus stall: 2-cycle ack delay and stall=1 for 3 cycles at pc=0x8. Check imem_addr stable, Instruction held, and no request until stall drops.
- Redirect in VALID: taken with branch_address=0x43 at pc=0x4. Check instr_valid drops and next imem_addr=0x40.
- Squash in flight: request at 0xC pending 3 cycles, taken=0x200 on cycle 1. Check addr stays 0xC until ack, data discarded, then addr=0x200, first valid pc=0x200.
- Wrap plus mid-request reset: taken to 0xFFFF_FFFC. Check next fetch is 0x0. Assert reset=0 during an unacked request and check imem_req=0 and state IDLE next cycle.
